// File: rtl/vga_board_renderer_if.sv
// Raster-in / pixel-out bundle between the VGA timing generator, the game
// state and the board renderer.
interface vga_board_renderer_if #(
   parameter int BOARD_N = 6
);
   localparam int AW = $clog2(BOARD_N * BOARD_N);

   logic [9:0]                   h_cnt;
   logic [9:0]                   v_cnt;
   logic                         valid;
   logic [2*BOARD_N*BOARD_N-1:0] board;
   logic [1:0]                   player;
   logic [AW-1:0]                cursor;
   logic [3:0]                   vga_red;
   logic [3:0]                   vga_grn;
   logic [3:0]                   vga_blu;
   logic                         frame_tick;

   // Source side: timing generator plus game state; consumes pixels.
   modport master (
      output h_cnt, v_cnt, valid, board, player, cursor,
      input  vga_red, vga_grn, vga_blu, frame_tick
   );

   // Renderer side.
   modport slave (
      input  h_cnt, v_cnt, valid, board, player, cursor,
      output vga_red, vga_grn, vga_blu, frame_tick
   );
endinterface

// File: rtl/vga_board_renderer.sv
// Two-stage pipelined Gomoku board renderer. Stage 1 classifies the raster
// position (disabled / in-board / turn frame / cell index / local edge bits).
// Stage 2 looks up a per-frame snapshot of the game state and picks a colour.
module vga_board_renderer #(
   parameter int          BOARD_N      = 6,
   parameter int          CELL_LOG2    = 6,
   parameter int          H_ACTIVE     = 640,
   parameter int          V_ACTIVE     = 480,
   parameter int          BLINK_FRAMES = 30,
   parameter int          FRAME_W      = 4,
   parameter logic [11:0] COLOR_BG     = 12'h235,
   parameter logic [11:0] COLOR_CELL   = 12'hC94,
   parameter logic [11:0] COLOR_GRID   = 12'h320,
   parameter logic [11:0] COLOR_BLACK  = 12'h111,
   parameter logic [11:0] COLOR_WHITE  = 12'hEEE,
   parameter logic [11:0] COLOR_MARK   = 12'hF00,
   parameter logic [11:0] COLOR_CURSOR = 12'h0F0
) (
   input logic                  clk,
   input logic                  rst_n,
   vga_board_renderer_if.slave  bus
);
   localparam int C     = 1 << CELL_LOG2;
   localparam int NCELL = BOARD_N * BOARD_N;
   localparam int BPX   = BOARD_N * C;
   localparam int AW    = $clog2(NCELL);
   localparam int IW    = $clog2(2 * NCELL);
   localparam int H_OFF = (H_ACTIVE - BPX) / 2;
   localparam int V_OFF = (V_ACTIVE - BPX) / 2;
   localparam int FH_LO = H_OFF - FRAME_W;
   localparam int FH_HI = H_OFF + BPX + FRAME_W;
   localparam int FV_LO = V_OFF - FRAME_W;
   localparam int FV_HI = V_OFF + BPX + FRAME_W;
   localparam int BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   // ---------------- stage 0: combinational classification ----------------
   logic [9:0]           hr, vr;
   logic [CELL_LOG2-1:0] lh, lv;
   logic                 vld0, inb0, frm0, fe;
   logic                 ring0, grid0, stone0;
   logic [AW-1:0]        idx0;

   // Board-relative coordinates wrap at 10 bits, so left/above the board
   // lands far out of range and fails the in-board test naturally.
   always_comb begin
      hr     = bus.h_cnt - 10'(H_OFF);
      vr     = bus.v_cnt - 10'(V_OFF);
      lh     = hr[CELL_LOG2-1:0];
      lv     = vr[CELL_LOG2-1:0];
      vld0   = bus.valid && (int'(bus.h_cnt) < H_ACTIVE) && (int'(bus.v_cnt) < V_ACTIVE);
      inb0   = (int'(hr) < BPX) && (int'(vr) < BPX);
      frm0   = (int'(bus.h_cnt) >= FH_LO) && (int'(bus.h_cnt) < FH_HI) &&
               (int'(bus.v_cnt) >= FV_LO) && (int'(bus.v_cnt) < FV_HI);
      idx0   = AW'(int'(vr >> CELL_LOG2) * BOARD_N + int'(hr >> CELL_LOG2));
      ring0  = (int'(lh) < 2) || (int'(lh) >= C - 2) || (int'(lv) < 2) || (int'(lv) >= C - 2);
      grid0  = (int'(lh) == 0) || (int'(lh) == C - 1) || (int'(lv) == 0) || (int'(lv) == C - 1);
      stone0 = (int'(lh) >= C / 8) && (int'(lh) < C - C / 8) &&
               (int'(lv) >= C / 8) && (int'(lv) < C - C / 8);
      fe     = bus.valid && (bus.h_cnt == 10'd0) && (int'(bus.v_cnt) == V_ACTIVE);
   end

   // ---------------- frame snapshot and blink state ----------------
   logic [2*NCELL-1:0] snap_board;
   logic [1:0]         snap_player;
   logic [AW-1:0]      snap_cursor;
   logic [BW-1:0]      blink_cnt;
   logic               blink_on;
   logic               tick_q;

   // Latch game state once per frame on the first blank line so a frame never tears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_board  <= '0;
         snap_player <= '0;
         snap_cursor <= '0;
         blink_cnt   <= '0;
         blink_on    <= 1'b1;
         tick_q      <= 1'b0;
      end else begin
         tick_q <= fe;
         if (fe) begin
            snap_board  <= bus.board;
            snap_player <= bus.player;
            snap_cursor <= bus.cursor;
            if (int'(blink_cnt) == BLINK_FRAMES - 1) begin
               blink_cnt <= '0;
               blink_on  <= ~blink_on;
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
         end
      end
   end

   // ---------------- stage 1 registers ----------------
   logic          s1_vld, s1_inb, s1_frm, s1_ring, s1_grid, s1_stone;
   logic [AW-1:0] s1_idx;

   // Register the position classification.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld   <= 1'b0;
         s1_inb   <= 1'b0;
         s1_frm   <= 1'b0;
         s1_ring  <= 1'b0;
         s1_grid  <= 1'b0;
         s1_stone <= 1'b0;
         s1_idx   <= '0;
      end else begin
         s1_vld   <= vld0;
         s1_inb   <= inb0;
         s1_frm   <= frm0;
         s1_ring  <= ring0;
         s1_grid  <= grid0;
         s1_stone <= stone0;
         s1_idx   <= idx0;
      end
   end

   // ---------------- stage 2: lookup and colour mux ----------------
   logic [IW-1:0] bidx;
   logic [1:0]    cell_v;
   logic          cur_hit;
   logic [11:0]   pix_c, rgb_q;

   // Pick the pixel colour from the snapshot; priority cursor > grid > stone > cell.
   always_comb begin
      bidx    = IW'(s1_idx) << 1;
      cell_v  = 2'd0;
      if (int'(s1_idx) < NCELL) cell_v = snap_board[bidx +: 2];
      // An out-of-range cursor never matches an in-board cell.
      cur_hit = blink_on && (int'(snap_cursor) < NCELL) && (snap_cursor == s1_idx);
      pix_c   = 12'h000;
      if (!s1_vld) begin
         pix_c = 12'h000;
      end else if (s1_inb) begin
         if (cur_hit && s1_ring)               pix_c = COLOR_CURSOR;
         else if (s1_grid)                     pix_c = COLOR_GRID;
         else if (s1_stone && cell_v == 2'd1)  pix_c = COLOR_BLACK;
         else if (s1_stone && cell_v == 2'd2)  pix_c = COLOR_WHITE;
         else if (s1_stone && cell_v == 2'd3)  pix_c = COLOR_MARK;
         else                                  pix_c = COLOR_CELL;
      end else if (s1_frm) begin
         case (snap_player)
            2'd1:    pix_c = COLOR_BLACK;
            2'd2:    pix_c = COLOR_WHITE;
            default: pix_c = COLOR_BG;
         endcase
      end else begin
         pix_c = COLOR_BG;
      end
   end

   // Output pixel register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rgb_q <= 12'h000;
      else        rgb_q <= pix_c;
   end

   assign bus.vga_red    = rgb_q[11:8];
   assign bus.vga_grn    = rgb_q[7:4];
   assign bus.vga_blu    = rgb_q[3:0];
   assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_vga_board_renderer.sv
// Directed bench for vga_board_renderer (6x6 board, 64-px cells, 2-frame blink).
module tb_vga_board_renderer;
   localparam logic [11:0] BG     = 12'h235;
   localparam logic [11:0] CELL   = 12'hC94;
   localparam logic [11:0] GRID   = 12'h320;
   localparam logic [11:0] BLACK  = 12'h111;
   localparam logic [11:0] WHITE  = 12'hEEE;
   localparam logic [11:0] MARK   = 12'hF00;
   localparam logic [11:0] CURSOR = 12'h0F0;

   logic clk;
   logic rst_n;
   int   n_chk  = 0;
   int   n_fail = 0;

   vga_board_renderer_if #(.BOARD_N(6)) bus ();

   vga_board_renderer #(
      .BOARD_N(6), .CELL_LOG2(6), .H_ACTIVE(640), .V_ACTIVE(480),
      .BLINK_FRAMES(2), .FRAME_W(4),
      .COLOR_BG(BG), .COLOR_CELL(CELL), .COLOR_GRID(GRID), .COLOR_BLACK(BLACK),
      .COLOR_WHITE(WHITE), .COLOR_MARK(MARK), .COLOR_CURSOR(CURSOR)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [11:0] rgb;
   assign rgb = {bus.vga_red, bus.vga_grn, bus.vga_blu};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one pixel and return #1 after the edge where its colour appears.
   task automatic pix(input int h, input int v, input logic vld);
      bus.h_cnt = 10'(h);
      bus.v_cnt = 10'(v);
      bus.valid = vld;
      @(posedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic frame_event();
      bus.h_cnt = 10'd0;
      bus.v_cnt = 10'd480;
      bus.valid = 1'b1;
      @(posedge clk); #1;
      chk("tick_high", {11'd0, bus.frame_tick}, 12'd1);
      bus.h_cnt = 10'd1;
      @(posedge clk); #1;
      chk("tick_low", {11'd0, bus.frame_tick}, 12'd0);
   endtask

   task automatic set_cell(input int i, input logic [1:0] val);
      bus.board[2*i +: 2] = val;
   endtask

   initial begin
      rst_n      = 1'b0;
      bus.h_cnt  = 10'd160;
      bus.v_cnt  = 10'd80;
      bus.valid  = 1'b1;
      bus.board  = '0;
      bus.player = 2'd0;
      bus.cursor = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_rgb", rgb, 12'h000);
      chk("reset_tick", {11'd0, bus.frame_tick}, 12'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("latency_1clk", rgb, 12'h000);
      @(posedge clk); #1;
      chk("reset_snap_cell", rgb, CELL);
      pix(128, 48, 1'b1);
      chk("reset_cursor0", rgb, CURSOR);

      // First snapshot: black stone in cell 0, black to move, cursor parked off-board.
      set_cell(0, 2'd1);
      bus.player = 2'd1;
      bus.cursor = 6'd36;
      frame_event();
      pix(128, 48, 1'b1);  chk("grid_corner", rgb, GRID);
      pix(160, 80, 1'b1);  chk("stone_black", rgb, BLACK);
      pix(125, 200, 1'b1); chk("frame_p1", rgb, BLACK);
      pix(120, 200, 1'b1); chk("bg_p1", rgb, BG);

      // Mid-frame change stays invisible until the next snapshot.
      set_cell(7, 2'd2);
      bus.cursor = 6'd7;
      pix(224, 144, 1'b1); chk("midframe_hidden", rgb, CELL);
      pix(193, 113, 1'b1); chk("cursor_hidden", rgb, CELL);
      frame_event();  // blink off
      pix(224, 144, 1'b1); chk("stone_white", rgb, WHITE);
      pix(193, 113, 1'b1); chk("blink_off_a", rgb, CELL);
      frame_event();  // still off
      pix(193, 113, 1'b1); chk("blink_off_b", rgb, CELL);
      frame_event();  // on
      pix(193, 113, 1'b1); chk("blink_on_a", rgb, CURSOR);
      pix(192, 112, 1'b1); chk("cursor_over_grid", rgb, CURSOR);
      pix(224, 144, 1'b1); chk("stone_in_cursor_cell", rgb, WHITE);
      frame_event();  // still on
      pix(193, 113, 1'b1); chk("blink_on_b", rgb, CURSOR);
      frame_event();  // off
      pix(193, 113, 1'b1); chk("blink_off_c", rgb, CELL);

      // Turn frame for white and for "none".
      bus.player = 2'd2;
      frame_event();  // off
      pix(125, 200, 1'b1); chk("frame_p2", rgb, WHITE);
      pix(120, 200, 1'b1); chk("bg_p2", rgb, BG);
      pix(124, 44, 1'b1);  chk("frame_corner", rgb, WHITE);
      pix(515, 200, 1'b1); chk("frame_right", rgb, WHITE);
      pix(516, 200, 1'b1); chk("bg_right", rgb, BG);
      bus.player = 2'd3;
      frame_event();  // on
      pix(125, 200, 1'b1); chk("frame_p3", rgb, BG);
      pix(120, 200, 1'b1); chk("bg_p3", rgb, BG);

      // Disabled pixels.
      pix(160, 80, 1'b0);  chk("dis_valid", rgb, 12'h000);
      pix(700, 80, 1'b1);  chk("dis_h", rgb, 12'h000);
      pix(160, 480, 1'b1); chk("dis_v", rgb, 12'h000);

      // Out-of-range cursor, mark stone.
      bus.cursor = 6'd36;
      set_cell(0, 2'd3);
      frame_event();  // on
      pix(193, 113, 1'b1); chk("cursor36_ring", rgb, CELL);
      pix(128, 48, 1'b1);  chk("cursor36_grid", rgb, GRID);
      pix(160, 80, 1'b1);  chk("stone_mark", rgb, MARK);

      // Asynchronous reset mid-line with a visible pixel held at the input.
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_rgb", rgb, 12'h000);
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_reset_lat", rgb, 12'h000);
      @(posedge clk); #1;
      chk("post_reset_snap", rgb, CELL);
      pix(128, 48, 1'b1);  chk("post_reset_cursor", rgb, CURSOR);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/vga_board_renderer.md
# vga_board_renderer

Pipelined, parametrised successor to the combinational board-to-VGA pixel generator. Given a raster position, it renders an N×N Gomoku board as 12-bit RGB with the following features:
- a cell size set by a parameter;
- a board snapshot taken once per frame (tear-free);
- a blinking cursor ring;
- a border frame that shows whose turn it is.

It sits between the VGA timing generator (h_cnt/v_cnt/valid) and the 4-bit-per-channel VGA pins.

## Interface
Parameters:
- BOARD_N, 6, cells per row and column.
- CELL_LOG2, 6, log2 of the cell edge in pixels. Cell edge is C = 2^CELL_LOG2 and must be ≥ 8.
- H_ACTIVE, 640, visible width in pixels.
- V_ACTIVE, 480, visible height in pixels.
- BLINK_FRAMES, 30, number of frames per cursor blink phase. Must be ≥ 1.
- FRAME_W, 4, width of the turn-indicator frame in pixels.
- COLOR_BG / COLOR_CELL / COLOR_GRID / COLOR_BLACK / COLOR_WHITE / COLOR_MARK / COLOR_CURSOR, 12-bit colour constants with defaults from colors.vh.

Derived values:
- AW = $clog2(BOARD_N·BOARD_N).
- H_OFF = (H_ACTIVE − BOARD_N·C)/2 and V_OFF = (V_ACTIVE − BOARD_N·C)/2. Both must be ≥ FRAME_W.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- h_cnt  in  10  horizontal raster position.
- v_cnt  in  10  vertical raster position.
- valid  in  1  timing generator valid.
- board  in  2·BOARD_N²  cell i occupies bits [2i+1:2i]. Cell index is row-major: i = row·BOARD_N + col.
- player  in  2  side to move: 1 = black, 2 = white, anything else = none.
- cursor  in  AW  selected cell index.
- vga_red  out  4  red channel.
- vga_grn  out  4  green channel.
- vga_blu  out  4  blue channel.
- frame_tick  out  1  one-cycle pulse when the snapshot is taken.

## Operation
- **Disabled pixel:** a pixel is disabled if ~valid, h_cnt ≥ H_ACTIVE, or v_cnt ≥ V_ACTIVE. A disabled pixel outputs RGB 12'h000.
- **Frame event:** asserted on the cycle where valid && h_cnt == 0 && v_cnt == V_ACTIVE (first blank line). On that clock edge:
  - board, player and cursor are copied into snapshot registers;
  - the blink counter advances;
  - frame_tick is driven high for the following cycle.
- **Rendering source:** all rendering uses only the snapshot registers, never the live board/player/cursor inputs.
- **Blink counter:**
  - counts 0..BLINK_FRAMES−1;
  - on the frame event at count BLINK_FRAMES−1 it wraps to 0 and toggles blink_on;
  - reset values: count 0, blink_on 1.
- **Board-relative coordinates:** h = h_cnt − H_OFF and v = v_cnt − V_OFF, both 10-bit with wrap.
  - In-board when h < BOARD_N·C and v < BOARD_N·C.
  - col = h >> CELL_LOG2, lh = h[CELL_LOG2−1:0].
  - row = v >> CELL_LOG2, lv = v[CELL_LOG2−1:0].
- **In-board pixel priority (highest first):**
  1. Cursor ring: snapshot cursor == cell index, blink_on = 1, and lh or lv is < 2 or ≥ C−2 → COLOR_CURSOR.
  2. Grid line: lh or lv is 0 or C−1 → COLOR_GRID.
  3. Stone: lh and lv both in [C/8, C−C/8) and cell value ≠ 0. Value 1 → COLOR_BLACK, 2 → COLOR_WHITE, 3 → COLOR_MARK.
  4. Otherwise → COLOR_CELL.
- **Cursor out of range:** a cursor ≥ BOARD_N² highlights nothing.
- **Out-of-board pixel, not disabled:**
  - Within FRAME_W pixels outside the board edge (corners included), the pixel takes the snapshot player colour: 1 → COLOR_BLACK, 2 → COLOR_WHITE, else COLOR_BG.
  - All other out-of-board pixels → COLOR_BG.
- **Reset:**
  - Snapshot board = all 0, player 0, cursor 0.
  - All pipeline registers cleared; outputs 12'h000; frame_tick 0.

## Timing
- Two-stage pipeline with latency exactly 2 clocks. Inputs sampled at edge k produce the output after edge k+2.
  - Stage 1 registers: disabled, in-board, frame-region, cell index, lh/lv class bits.
  - Stage 2 registers: the snapshot lookup plus colour mux, written to the output registers.
- Throughput is one pixel per clock with no stalls.
- Snapshot update and blink toggle take effect on pixels sampled on or after the edge following the frame event. That first blank line is disabled, so no visible pixel mixes old and new state.
- frame_tick rises exactly 1 cycle after the frame-event input sample and stays high for 1 cycle.
- Board changes mid-frame are not visible until the next frame event.
- rst_n assertion clears all state asynchronously, including in-flight pipeline data. After deassertion, outputs stay 12'h000 for at least 2 clocks, even with valid input.

## Test plan
- Default parameters, frame event with board cell 0 = 1 and player = 1. Then h=128, v=48 gives COLOR_GRID 2 clocks later, and h=160, v=80 gives COLOR_BLACK.
- Board cell 7 = 2 loaded mid-frame: no change at h=224, v=144 until after the next frame event, then COLOR_WHITE.
- Cursor = 7, BLINK_FRAMES=2: pixel h=193, v=113 shows COLOR_CURSOR in frames 0–1, COLOR_GRID-free COLOR_CELL path in frames 2–3, and repeats. frame_tick pulses once per frame.
- Player = 2: h=125, v=200 → COLOR_WHITE and h=120, v=200 → COLOR_BG. Player = 3 gives COLOR_BG at both.
- valid=0, h=700, or v=480 → 12'h000. Cursor = 36 → no ring anywhere.
- rst_n pulsed mid-line: outputs immediately 12'h000, snapshot cleared, and the first rendered pixel appears 2 clocks after deassertion.
